exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Exception/interrupt controller directly upstream of the PC register in the multi-cycle CPU.
//  Generates the illop/xadr redirect strobes that the PC register consumes, and the XP save write.
//  Samples at instruction boundaries (pc_we), synchronises the async external interrupt,
//  and blocks interrupts in kernel mode (pc_cur[31]=1).
// PARAMETERS
//  IRQ_EDGE    1   1: rising edge of synced irq sets pending; 0: pending follows synced level
//  SYNC_STAGES 2   irq synchroniser depth, legal 2..3
//  CNT_W       16  width of statistics counters (EXC_STATS_EN only)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  irq_i       in   1      external interrupt request, asynchronous to clk
//  pc_cur      in   32     current PC (PC register output)
//  pc_we       in   1      instruction-commit cycle: PC loads its next value at this clk edge
//  illegal_i   in   1      decoder: current instruction is illegal, valid when pc_we=1
//  illop       out  1      to PC register: vector to ILLOP handler this edge (combinational)
//  xadr        out  1      to PC register: vector to interrupt handler this edge (combinational)
//  xp_we       out  1      register-file write enable for XP (combinational)
//  xp_data     out  32     value written to XP
//  irq_ack     out  1      registered 1-cycle pulse, cycle after an interrupt is taken
//  exc_cause   out  2      registered: 00 none, 01 illop, 10 interrupt; holds until next exception
//  illop_cnt   out  CNT_W  EXC_STATS_EN only: illops taken
//  irq_cnt     out  CNT_W  EXC_STATS_EN only: interrupts taken
// BEHAVIOUR
//  Sync: irq_i -> SYNC_STAGES flops -> irq_s; one extra flop irq_d for edge detection.
//  Kernel mode: kernel = pc_cur[31]; kernel_q is that value registered.
//  pend:
//   IRQ_EDGE=1: set on irq_s & ~irq_d; cleared only when the interrupt is taken.
//    A set and a take in the same cycle leave pend=1.
//   IRQ_EDGE=0: pend = irq_s. The device must drop irq_i in the handler.
//  guard:
//   Set when kernel_q=1 & kernel=0 (return to user mode).
//   Cleared at the first pc_we with kernel=0.
//   Guarantees one user instruction commits between handler exit and the next interrupt.
//  Strobes:
//   illop   = pc_we & illegal_i, in any mode.
//   take    = pc_we & pend & ~kernel & ~guard & ~illegal_i
//   xadr    = take
//   xp_we   = illop | xadr
//   xp_data = {pc_cur[31], pc_cur[30:0]+31'd4}; bit 31 is preserved, low 31 bits wrap modulo 2^31.
//  Simultaneous: illop wins; interrupt remains pending and is retaken on a later user boundary.
//  Latency: the irq_i rise needs SYNC_STAGES+1 clks before pend=1. xadr fires at the first
//   qualifying pc_we after that.
//  FSM (state = {pend,guard}):
//   IDLE    -> PEND on pend set
//   PEND    -> IDLE on take
//   any     -> GUARD on kernel->user transition
//   GUARD   -> IDLE or PEND on the first user pc_we
//  Registered outputs:
//   irq_ack <= take.
//   exc_cause <= 01 on illop, 10 on take, else hold.
//  Reset (sync, highest priority): every flop is cleared at the reset clk edge, regardless of pend/guard.
//   Cleared: sync chain, irq_d, pend, guard, kernel_q, irq_ack, exc_cause=00, counters=0.
//   During a reset cycle the combinational strobes still follow inputs; the PC register's reset overrides.
// CONFIGURATION
//  EXC_STATS_EN defined:
//   Adds illop_cnt and irq_cnt ports.
//   Each counter increments by 1 per taken illop / take and saturates at all-ones.
//   Both clear on reset.
//  EXC_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset: hold reset 2 clks with irq_i=1 -> pend=0, exc_cause=00, irq_ack=0, counters 0.
//  2. Illop: pc_cur=0x00000010, pc_we=1, illegal_i=1
//     -> illop=1, xp_we=1, xp_data=0x00000014; exc_cause=01 next clk.
//  3. Irq user mode (IRQ_EDGE=1, SYNC_STAGES=2): raise irq_i at clk0, pc_we every clk,
//     pc_cur=0x00000100 -> xadr=1 at clk3, xp_data=0x00000104, irq_ack=1 at clk4,
//     pend=0 afterwards.
//  4. Kernel block and guard: irq pending while pc_cur=0x80000040 -> no xadr.
//     Then pc_cur=0x00000200 -> first pc_we commits without xadr; xadr fires on the second pc_we.
//  5. Collision: pend=1, user mode, pc_we=1, illegal_i=1 -> illop=1, xadr=0, pend stays 1;
//     next user pc_we -> xadr=1.
//  6. Wrap/saturation: pc_cur=0xFFFFFFFC with illegal -> xp_data=0x80000000.
//     With EXC_STATS_EN, 2^CNT_W+3 illops -> illop_cnt = all-ones.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/interrupt redirect controller feeding the PC register and the XP write port.
// Optional statistics counters (illop_cnt, irq_cnt) are built when EXC_STATS_EN is defined.
module exc_ctrl #(
  parameter int IRQ_EDGE    = 1,
  parameter int SYNC_STAGES = 2
`ifdef EXC_STATS_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_i,
  input  logic [31:0] pc_cur,
  input  logic        pc_we,
  input  logic        illegal_i,
  output logic        illop,
  output logic        xadr,
  output logic        xp_we,
  output logic [31:0] xp_data,
  output logic        irq_ack,
  output logic [1:0]  exc_cause
`ifdef EXC_STATS_EN
  , output logic [CNT_W-1:0] illop_cnt
  , output logic [CNT_W-1:0] irq_cnt
`endif
);

  // state   | meaning
  // IDLE    | nothing pending, interrupts allowed
  // GUARD   | just returned to user mode, no interrupt pending
  // PEND    | interrupt pending, waiting for a user boundary
  // PEND_GD | interrupt pending, held off until one user instruction commits
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GUARD   = 2'b01,
    PEND    = 2'b10,
    PEND_GD = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_s, irq_d;
  logic                   kernel, kernel_q;
  logic                   pend, guard, ret_user, guard_act, take;
  logic                   pend_nx, guard_nx;

  assign irq_s  = sync_q[SYNC_STAGES-1];
  assign kernel = pc_cur[31];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      irq_d     <= 1'b0;
      kernel_q  <= 1'b0;
      irq_ack   <= 1'b0;
      exc_cause <= 2'b00;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_i};
      irq_d    <= irq_s;
      kernel_q <= kernel;
      irq_ack  <= take;
      if (illop)
        exc_cause <= 2'b01;
      else if (take)
        exc_cause <= 2'b10;
    end
  end

  always_comb begin
    pend      = state_q[1];
    guard     = state_q[0];
    ret_user  = kernel_q & ~kernel;
    // The return cycle itself must already block, so the guard acts combinationally.
    guard_act = guard | ret_user;
    take      = pc_we & pend & ~kernel & ~guard_act & ~illegal_i;
    // Level mode: the pend bit tracks what irq_s becomes at this edge.
    if (IRQ_EDGE != 0)
      pend_nx = (irq_s & ~irq_d) | (pend & ~take);
    else
      pend_nx = sync_q[SYNC_STAGES-2];
    guard_nx  = guard_act & ~(pc_we & ~kernel);
    state_d   = state_t'({pend_nx, guard_nx});
  end

  assign illop   = pc_we & illegal_i;
  assign xadr    = take;
  assign xp_we   = illop | xadr;
  assign xp_data = {pc_cur[31], pc_cur[30:0] + 31'd4};

`ifdef EXC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      illop_cnt <= '0;
      irq_cnt   <= '0;
    end else begin
      if (illop && (illop_cnt != {CNT_W{1'b1}}))
        illop_cnt <= illop_cnt + 1'b1;
      if (take && (irq_cnt != {CNT_W{1'b1}}))
        irq_cnt <= irq_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_exc_ctrl;
  localparam int IRQ_EDGE = 1;
  localparam int S        = 2;
`ifdef EXC_STATS_EN
  localparam int CNT_W    = 16;
`endif

  logic        clk = 1'b0;
  logic        reset, irq_i, pc_we, illegal_i;
  logic [31:0] pc_cur;
  logic        illop, xadr, xp_we, irq_ack;
  logic [31:0] xp_data;
  logic [1:0]  exc_cause;
`ifdef EXC_STATS_EN
  logic [CNT_W-1:0] illop_cnt, irq_cnt;
  logic [CNT_W-1:0] m_icnt, m_qcnt;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        hist [0:S];    // hist[k]: irq_i sampled k+1 edges ago
  logic        m_pend, m_prev_kernel, m_ack;
  logic [1:0]  m_cause;
  int          m_since_ret;   // user commits since the last return to user mode
  logic        e_illop, e_xadr, e_xpwe;
  logic [31:0] e_xpdata;

  exc_ctrl #(.IRQ_EDGE(IRQ_EDGE), .SYNC_STAGES(S)
`ifdef EXC_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .pc_cur(pc_cur), .pc_we(pc_we),
    .illegal_i(illegal_i), .illop(illop), .xadr(xadr), .xp_we(xp_we),
    .xp_data(xp_data), .irq_ack(irq_ack), .exc_cause(exc_cause)
`ifdef EXC_STATS_EN
    , .illop_cnt(illop_cnt), .irq_cnt(irq_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_comb();
    logic kern, pend_now, allowed;
    kern     = pc_cur[31];
    pend_now = (IRQ_EDGE != 0) ? m_pend : hist[S-1];
    allowed  = !(m_prev_kernel && !kern) && (m_since_ret >= 1);
    e_illop  = pc_we & illegal_i;
    e_xadr   = pc_we & pend_now & ~kern & allowed & ~illegal_i;
    e_xpwe   = e_illop | e_xadr;
    e_xpdata = (pc_cur & 32'h8000_0000) | ((pc_cur + 32'd4) & 32'h7FFF_FFFF);
  endtask

  // one clock edge: advance model from the inputs of the ending cycle
  task automatic tick();
    logic kern, rise;
    model_comb();
    kern = pc_cur[31];
    rise = hist[S-1] & ~hist[S];
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k <= S; k++) hist[k] = 1'b0;
      m_pend = 0; m_prev_kernel = 0; m_ack = 0; m_cause = 2'b00; m_since_ret = 1;
`ifdef EXC_STATS_EN
      m_icnt = '0; m_qcnt = '0;
`endif
    end else begin
      m_pend = rise | (m_pend & ~e_xadr);
      if (m_prev_kernel && !kern) m_since_ret = 0;
      if (pc_we && !kern && m_since_ret < 2) m_since_ret++;
      m_prev_kernel = kern;
      m_ack = e_xadr;
      if (e_illop) m_cause = 2'b01;
      else if (e_xadr) m_cause = 2'b10;
`ifdef EXC_STATS_EN
      if (e_illop && m_icnt != {CNT_W{1'b1}}) m_icnt++;
      if (e_xadr && m_qcnt != {CNT_W{1'b1}}) m_qcnt++;
`endif
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_i;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; irq_i = 0; pc_we = 0; illegal_i = 0; pc_cur = 32'h0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; irq_i = 1; pc_we = 0; illegal_i = 0; pc_cur = 32'h0000_0100;
    tick(); tick();
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", irq_ack); end
    checks++; if (exc_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b exp 00", exc_cause); end
`ifdef EXC_STATS_EN
    checks++; if (illop_cnt !== '0 || irq_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h/%h exp 0", illop_cnt, irq_cnt); end
`endif
    reset = 0; pc_we = 1; #1;
    checks++; if (xadr !== 1'b0) begin errors++; $display("FAIL reset_pend got xadr=%b exp 0", xadr); end
    tick();
  endtask

  task automatic test_illop();
    do_reset();
    pc_cur = 32'h0000_0010; pc_we = 1; illegal_i = 1; #1;
    checks++; if (illop !== 1'b1) begin errors++; $display("FAIL illop_strobe got %b exp 1", illop); end
    checks++; if (xp_we !== 1'b1) begin errors++; $display("FAIL illop_xpwe got %b exp 1", xp_we); end
    checks++; if (xp_data !== 32'h0000_0014) begin errors++; $display("FAIL illop_xpdata got %h exp 00000014", xp_data); end
    checks++; if (xadr !== 1'b0) begin errors++; $display("FAIL illop_xadr got %b exp 0", xadr); end
    tick();
    checks++; if (exc_cause !== 2'b01) begin errors++; $display("FAIL illop_cause got %b exp 01", exc_cause); end
    illegal_i = 0; pc_we = 0;
  endtask

  task automatic test_irq_user();
    do_reset();
    pc_cur = 32'h0000_0100; pc_we = 1; irq_i = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (xadr !== 1'b0) begin errors++; $display("FAIL irq_early c%0d got %b exp 0", c, xadr); end
      tick();
    end
    #1;
    checks++; if (xadr !== 1'b1) begin errors++; $display("FAIL irq_take got %b exp 1", xadr); end
    checks++; if (xp_data !== 32'h0000_0104) begin errors++; $display("FAIL irq_xpdata got %h exp 00000104", xp_data); end
    tick();
    checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ack got %b exp 1", irq_ack); end
    checks++; if (exc_cause !== 2'b10) begin errors++; $display("FAIL irq_cause got %b exp 10", exc_cause); end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (xadr !== 1'b0) begin errors++; $display("FAIL irq_cleared c%0d got %b exp 0", c, xadr); end
      tick();
    end
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL irq_ack_pulse got %b exp 0", irq_ack); end
    irq_i = 0;
  endtask

  task automatic test_kernel_guard();
    do_reset();
    pc_cur = 32'h8000_0040; pc_we = 1; irq_i = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (xadr !== 1'b0) begin errors++; $display("FAIL kernel_block c%0d got %b exp 0", c, xadr); end
      tick();
    end
    pc_cur = 32'h0000_0200; #1;
    checks++; if (xadr !== 1'b0) begin errors++; $display("FAIL guard_first got %b exp 0", xadr); end
    tick();
    checks++; if (xadr !== 1'b1) begin errors++; $display("FAIL guard_second got %b exp 1", xadr); end
    checks++; if (xp_data !== 32'h0000_0204) begin errors++; $display("FAIL guard_xpdata got %h exp 00000204", xp_data); end
    tick();
    irq_i = 0;
  endtask

  task automatic test_collision();
    do_reset();
    pc_cur = 32'h0000_0300; pc_we = 0; irq_i = 1;
    repeat (4) tick();
    pc_we = 1; illegal_i = 1; #1;
    checks++; if (illop !== 1'b1 || xadr !== 1'b0) begin errors++; $display("FAIL coll_strobes got illop=%b xadr=%b exp 1/0", illop, xadr); end
    tick();
    checks++; if (exc_cause !== 2'b01) begin errors++; $display("FAIL coll_cause got %b exp 01", exc_cause); end
    illegal_i = 0; #1;
    checks++; if (xadr !== 1'b1) begin errors++; $display("FAIL coll_retake got %b exp 1", xadr); end
    tick();
    checks++; if (exc_cause !== 2'b10 || irq_ack !== 1'b1) begin errors++; $display("FAIL coll_after got cause=%b ack=%b exp 10/1", exc_cause, irq_ack); end
    irq_i = 0; pc_we = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    pc_cur = 32'hFFFF_FFFC; pc_we = 1; illegal_i = 1; #1;
    checks++; if (xp_data !== 32'h8000_0000 || illop !== 1'b1) begin errors++; $display("FAIL wrap_kernel got %h illop=%b exp 80000000/1", xp_data, illop); end
    tick();
    pc_cur = 32'h7FFF_FFFC; #1;
    checks++; if (xp_data !== 32'h0000_0000) begin errors++; $display("FAIL wrap_user got %h exp 00000000", xp_data); end
    tick();
`ifdef EXC_STATS_EN
    do_reset();
    pc_cur = 32'h0000_0040; pc_we = 1; illegal_i = 1;
    repeat ((1 << CNT_W) + 3) tick();
    checks++; if (illop_cnt !== {CNT_W{1'b1}}) begin errors++; $display("FAIL sat_illop got %h exp all-ones", illop_cnt); end
    checks++; if (irq_cnt !== '0) begin errors++; $display("FAIL sat_irq got %h exp 0", irq_cnt); end
`endif
    illegal_i = 0; pc_we = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) irq_i = ~irq_i;
      if ($urandom_range(0, 3) == 0)
        pc_cur = {($urandom_range(0, 2) == 0), 31'($urandom)};
      pc_we     = $urandom_range(0, 1);
      illegal_i = ($urandom_range(0, 7) == 0);
      #1;
      model_comb();
      checks++; if (illop !== e_illop) begin errors++; $display("FAIL rnd_illop n%0d got %b exp %b", n, illop, e_illop); end
      checks++; if (xadr !== e_xadr) begin errors++; $display("FAIL rnd_xadr n%0d got %b exp %b", n, xadr, e_xadr); end
      checks++; if (xp_we !== e_xpwe) begin errors++; $display("FAIL rnd_xpwe n%0d got %b exp %b", n, xp_we, e_xpwe); end
      checks++; if (xp_data !== e_xpdata) begin errors++; $display("FAIL rnd_xpdata n%0d got %h exp %h", n, xp_data, e_xpdata); end
      tick();
      checks++; if (irq_ack !== m_ack) begin errors++; $display("FAIL rnd_ack n%0d got %b exp %b", n, irq_ack, m_ack); end
      checks++; if (exc_cause !== m_cause) begin errors++; $display("FAIL rnd_cause n%0d got %b exp %b", n, exc_cause, m_cause); end
`ifdef EXC_STATS_EN
      checks++; if (illop_cnt !== m_icnt || irq_cnt !== m_qcnt) begin errors++; $display("FAIL rnd_cnt n%0d got %h/%h exp %h/%h", n, illop_cnt, irq_cnt, m_icnt, m_qcnt); end
`endif
    end
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k <= S; k++) hist[k] = 1'b0;
    m_pend = 0; m_prev_kernel = 0; m_ack = 0; m_cause = 2'b00; m_since_ret = 1;
`ifdef EXC_STATS_EN
    m_icnt = '0; m_qcnt = '0;
`endif
    reset = 1; irq_i = 0; pc_we = 0; illegal_i = 0; pc_cur = 32'h0;
    #2;
    test_reset();
    test_illop();
    test_irq_user();
    test_kernel_guard();
    test_collision();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
